// File: rtl/display_seq_ctrl_if.sv
// Button, ALU handshake and display-select bundle between the calculator
// front end and display_seq_ctrl.
interface display_seq_ctrl_if;
    logic       btn_next;
    logic       btn_calc;
    logic       btn_clear;
    logic       alu_done;
    logic [1:0] display_mode;
    logic [1:0] chosen_operand;
    logic       alu_start;
    logic       result_valid;
    logic       error;
    logic [2:0] state_dbg;

    modport master (
        output btn_next, btn_calc, btn_clear, alu_done,
        input  display_mode, chosen_operand, alu_start, result_valid, error, state_dbg
    );

    modport slave (
        input  btn_next, btn_calc, btn_clear, alu_done,
        output display_mode, chosen_operand, alu_start, result_valid, error, state_dbg
    );
endinterface

// File: rtl/display_seq_ctrl.sv
// Operand-entry / compute / display sequencer for the calculator (Moore FSM).
// Optional macro DISP_AUTO_CYCLE_EN rotates result/A/B pages while in SHOW_RES.
module display_seq_ctrl #(
    parameter int IDLE_TIMEOUT = 100000000,
    parameter int CALC_TIMEOUT = 1024,
    parameter int CYCLE_PERIOD = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    display_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        BLANK    = 3'd0,
        ENTER_A  = 3'd1,
        ENTER_B  = 3'd2,
        START    = 3'd3,
        WAIT     = 3'd4,
        SHOW_RES = 3'd5,
        ERROR    = 3'd6
    } state_t;

    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int CALC_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [CALC_W-1:0] CALC_LAST = CALC_W'(CALC_TIMEOUT - 1);

    state_t            state_r, state_next_s;
    logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_next_s;
    logic [CALC_W-1:0] wait_cnt_r, wait_cnt_next_s;
    logic              any_btn_s, idle_state_s, idle_timeout_s, wait_timeout_s;
    logic [1:0]        mode_next_s, oper_next_s;
    logic [1:0]        display_mode_r, chosen_operand_r;
    logic              alu_start_r, result_valid_r, error_r;

    // Next-state logic; btn_clear overrides everything, and a button beats a coincident idle timeout
    always_comb begin
        any_btn_s      = bus.btn_next | bus.btn_calc | bus.btn_clear;
        idle_state_s   = (state_r == ENTER_A) || (state_r == ENTER_B) || (state_r == SHOW_RES);
        idle_timeout_s = (idle_cnt_r == IDLE_LAST) && !any_btn_s;
        wait_timeout_s = (wait_cnt_r == CALC_LAST);
        state_next_s   = state_r;
        if (bus.btn_clear) begin
            state_next_s = BLANK;
        end else begin
            case (state_r)
                BLANK: begin
                    if (bus.btn_next) state_next_s = ENTER_A;
                    else              state_next_s = BLANK;
                end
                ENTER_A: begin
                    if (bus.btn_next)       state_next_s = ENTER_B;
                    else if (idle_timeout_s) state_next_s = BLANK;
                    else                    state_next_s = ENTER_A;
                end
                ENTER_B, SHOW_RES: begin
                    if (bus.btn_next)        state_next_s = ENTER_A;
                    else if (bus.btn_calc)   state_next_s = START;
                    else if (idle_timeout_s) state_next_s = BLANK;
                    else                     state_next_s = state_r;
                end
                START: state_next_s = WAIT;
                WAIT: begin
                    if (bus.alu_done)        state_next_s = SHOW_RES;
                    else if (wait_timeout_s) state_next_s = ERROR;
                    else                     state_next_s = WAIT;
                end
                ERROR: begin
                    if (bus.btn_next) state_next_s = BLANK;
                    else              state_next_s = ERROR;
                end
                default: state_next_s = BLANK;
            endcase
        end
    end

    // Saturating counters; both restart whenever the state changes
    always_comb begin
        wait_cnt_next_s = {CALC_W{1'b0}};
        idle_cnt_next_s = {IDLE_W{1'b0}};
        if ((state_next_s == state_r) && (state_r == WAIT)) begin
            if (wait_cnt_r == {CALC_W{1'b1}}) wait_cnt_next_s = wait_cnt_r;
            else                              wait_cnt_next_s = wait_cnt_r + CALC_W'(1'b1);
        end else begin
            wait_cnt_next_s = {CALC_W{1'b0}};
        end
        if ((state_next_s == state_r) && idle_state_s && !any_btn_s) begin
            if (idle_cnt_r == {IDLE_W{1'b1}}) idle_cnt_next_s = idle_cnt_r;
            else                              idle_cnt_next_s = idle_cnt_r + IDLE_W'(1'b1);
        end else begin
            idle_cnt_next_s = {IDLE_W{1'b0}};
        end
    end

`ifdef DISP_AUTO_CYCLE_EN
    localparam int CYC_W = (CYCLE_PERIOD > 1) ? $clog2(CYCLE_PERIOD) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLE_PERIOD - 1);

    logic [CYC_W-1:0] cyc_cnt_r, cyc_cnt_next_s;
    logic [1:0]       page_r, page_next_s;

    // Page rotation result -> A -> B -> result, always restarting on the result page
    always_comb begin
        cyc_cnt_next_s = {CYC_W{1'b0}};
        page_next_s    = 2'd0;
        if ((state_next_s == SHOW_RES) && (state_r == SHOW_RES)) begin
            if (cyc_cnt_r == CYC_LAST) begin
                cyc_cnt_next_s = {CYC_W{1'b0}};
                page_next_s    = (page_r == 2'd2) ? 2'd0 : page_r + 2'd1;
            end else begin
                cyc_cnt_next_s = cyc_cnt_r + CYC_W'(1'b1);
                page_next_s    = page_r;
            end
        end else begin
            cyc_cnt_next_s = {CYC_W{1'b0}};
            page_next_s    = 2'd0;
        end
    end

    // Page counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt_r <= {CYC_W{1'b0}};
            page_r    <= 2'd0;
        end else begin
            cyc_cnt_r <= cyc_cnt_next_s;
            page_r    <= page_next_s;
        end
    end
`endif

    // Display select decode from the next state so the registered outputs track it
    always_comb begin
        mode_next_s = 2'b00;
        oper_next_s = 2'b00;
        case (state_next_s)
            ENTER_A: begin mode_next_s = 2'b01; oper_next_s = 2'b01; end
            ENTER_B: begin mode_next_s = 2'b01; oper_next_s = 2'b10; end
            SHOW_RES: begin
`ifdef DISP_AUTO_CYCLE_EN
                case (page_next_s)
                    2'd1:    begin mode_next_s = 2'b01; oper_next_s = 2'b01; end
                    2'd2:    begin mode_next_s = 2'b01; oper_next_s = 2'b10; end
                    default: begin mode_next_s = 2'b10; oper_next_s = 2'b00; end
                endcase
`else
                mode_next_s = 2'b10;
                oper_next_s = 2'b00;
`endif
            end
            default: begin mode_next_s = 2'b00; oper_next_s = 2'b00; end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= BLANK;
            idle_cnt_r       <= {IDLE_W{1'b0}};
            wait_cnt_r       <= {CALC_W{1'b0}};
            display_mode_r   <= 2'b00;
            chosen_operand_r <= 2'b00;
            alu_start_r      <= 1'b0;
            result_valid_r   <= 1'b0;
            error_r          <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            idle_cnt_r       <= idle_cnt_next_s;
            wait_cnt_r       <= wait_cnt_next_s;
            display_mode_r   <= mode_next_s;
            chosen_operand_r <= oper_next_s;
            alu_start_r      <= (state_next_s == START);
            result_valid_r   <= (state_next_s == SHOW_RES);
            error_r          <= (state_next_s == ERROR);
        end
    end

    assign bus.display_mode   = display_mode_r;
    assign bus.chosen_operand = chosen_operand_r;
    assign bus.alu_start      = alu_start_r;
    assign bus.result_valid   = result_valid_r;
    assign bus.error          = error_r;
    assign bus.state_dbg      = state_r;
endmodule

// File: tb/tb_display_seq_ctrl.sv
// Directed plus random stimulus for display_seq_ctrl, checked against a
// dwell-time reference model (honours DISP_AUTO_CYCLE_EN when defined).
module tb_display_seq_ctrl;
    localparam int IDLE_T = 20;
    localparam int CALC_T = 8;
    localparam int PER    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Model: current state, cycles since entering it, cycles without a button
    int m_state = 0;
    int m_dwell = 0;
    int m_idle  = 0;

    display_seq_ctrl_if bus ();

    display_seq_ctrl #(
        .IDLE_TIMEOUT(IDLE_T),
        .CALC_TIMEOUT(CALC_T),
        .CYCLE_PERIOD(PER)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_disp();
        int page;
        case (m_state)
            1: return 4'b0101;
            2: return 4'b0110;
            5: begin
`ifdef DISP_AUTO_CYCLE_EN
                page = (m_dwell / PER) % 3;
`else
                page = 0;
`endif
                if (page == 1)      return 4'b0101;
                else if (page == 2) return 4'b0110;
                else                return 4'b1000;
            end
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [3:0] d;
        d = exp_disp();
        return {d, (m_state == 3) ? 1'b1 : 1'b0, (m_state == 5) ? 1'b1 : 1'b0,
                (m_state == 6) ? 1'b1 : 1'b0, 3'(m_state)};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {bus.display_mode, bus.chosen_operand, bus.alu_start,
                bus.result_valid, bus.error, bus.state_dbg};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_dwell = 0;
        m_idle  = 0;
    endtask

    task automatic model_step(input bit nx, input bit calc, input bit clr, input bit done);
        int  ns;
        bit  btn;
        bit  idle_out;
        btn      = nx | calc | clr;
        idle_out = !btn && (m_idle == IDLE_T - 1);
        ns       = m_state;
        if (clr) ns = 0;
        else begin
            case (m_state)
                0: if (nx) ns = 1;
                1: if (nx) ns = 2; else if (idle_out) ns = 0;
                2, 5: if (nx) ns = 1; else if (calc) ns = 3; else if (idle_out) ns = 0;
                3: ns = 4;
                4: if (done) ns = 5; else if (m_dwell == CALC_T - 1) ns = 6;
                6: if (nx) ns = 0;
                default: ns = 0;
            endcase
        end
        m_idle  = (ns == m_state && !btn && (ns == 1 || ns == 2 || ns == 5)) ? m_idle + 1 : 0;
        m_dwell = (ns == m_state) ? m_dwell + 1 : 0;
        m_state = ns;
    endtask

    task automatic check(input string tag, input logic [9:0] expv);
        logic [9:0] got;
        got = obs_vec();
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: outputs got %03h expected %03h", tag, got, expv);
        end
    endtask

    task automatic tick(input bit nx, input bit calc, input bit clr, input bit done, input string tag);
        bus.btn_next  = nx;
        bus.btn_calc  = calc;
        bus.btn_clear = clr;
        bus.alu_done  = done;
        @(posedge clk);
        model_step(nx, calc, clr, done);
        #1;
        bus.btn_next  = 1'b0;
        bus.btn_calc  = 1'b0;
        bus.btn_clear = 1'b0;
        bus.alu_done  = 1'b0;
        check(tag, exp_vec());
    endtask

    initial begin
        bus.btn_next  = 1'b0;
        bus.btn_calc  = 1'b0;
        bus.btn_clear = 1'b0;
        bus.alu_done  = 1'b0;
        model_reset();
        #1;
        check("reset", exp_vec());
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        tick(1'b0, 1'b0, 1'b0, 1'b0, "blank_idle");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "blank_calc_ignored");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "to_enter_a");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "a_calc_ignored");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "to_enter_b");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "back_to_a");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "to_b_again");

        tick(1'b0, 1'b1, 1'b0, 1'b0, "start_strobe");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "wait_0");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "wait_1");
        tick(1'b0, 1'b0, 1'b0, 1'b1, "alu_done_show");
        tick(1'b0, 1'b0, 1'b0, 1'b1, "done_outside_wait");

        tick(1'b0, 1'b1, 1'b0, 1'b0, "recompute_start");
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "calc_timeout");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "error_calc_ignored");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "error_next_blank");

        tick(1'b1, 1'b0, 1'b0, 1'b0, "abort_a");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "abort_b");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "abort_start");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "abort_wait");
        tick(1'b0, 1'b0, 1'b1, 1'b1, "clear_beats_done");
        tick(1'b0, 1'b0, 1'b0, 1'b1, "late_done_ignored");

        tick(1'b1, 1'b0, 1'b0, 1'b0, "idle_enter_a");
        for (int i = 0; i < IDLE_T - 1; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "idle_count_a");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "btn_beats_idle");
        for (int i = 0; i < IDLE_T; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "idle_timeout_b");

        tick(1'b1, 1'b0, 1'b0, 1'b0, "res_a");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "res_b");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "res_start");
        tick(1'b0, 1'b0, 1'b0, 1'b1, "res_done");
        for (int i = 0; i < IDLE_T + 2; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "show_pages_idle");

        tick(1'b1, 1'b0, 1'b0, 1'b0, "rst_a");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "rst_b");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "rst_start");
        tick(1'b0, 1'b0, 1'b0, 1'b1, "rst_done");
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "rst_pages");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 10'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1, "after_reset");

        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
